// File: rtl/btb_2bit_predictor.sv
// Fully associative branch target buffer with per-entry 2-bit saturating
// direction counters; lowest free slot on allocate, round-robin victim when full.

module btb_entry #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            alloc_i,
    input  logic            upd_i,
    input  logic            upd_taken_i,
    input  logic [PC_W-1:0] upd_pc_i,
    input  logic [PC_W-1:0] upd_target_i,
    input  logic [PC_W-1:0] lkp_pc_i,
    output logic            valid_o,
    output logic            lkp_match_o,
    output logic            upd_match_o,
    output logic            ctr_msb_o,
    output logic [PC_W-1:0] target_o
);
    logic            valid_q, valid_d;
    logic [PC_W-1:0] tag_q, tag_d;
    logic [PC_W-1:0] target_q, target_d;
    logic [1:0]      ctr_q, ctr_d;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (alloc_i) begin
            valid_d  = 1'b1;
            tag_d    = upd_pc_i;
            target_d = upd_target_i;
            ctr_d    = 2'b10;
        end else if (upd_i) begin
            if (upd_taken_i) begin
                target_d = upd_target_i;
                if (ctr_q != 2'b11) ctr_d = ctr_q + 2'd1;
            end else if (ctr_q != 2'b00) begin
                ctr_d = ctr_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    // Payload is only observable through a valid entry, so it carries no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end

    assign valid_o     = valid_q;
    assign lkp_match_o = valid_q && (tag_q == lkp_pc_i);
    assign upd_match_o = valid_q && (tag_q == upd_pc_i);
    assign ctr_msb_o   = ctr_q[1];
    assign target_o    = target_q;
endmodule

module btb_2bit_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lkp_valid,
    input  logic [PC_W-1:0]            lkp_pc,
    output logic                       pred_hit,
    output logic                       pred_taken,
    output logic [PC_W-1:0]            pred_next_pc,
    input  logic                       upd_valid,
    input  logic [PC_W-1:0]            upd_pc,
    input  logic                       upd_taken,
    input  logic [PC_W-1:0]            upd_target,
    input  logic                       flush,
    output logic [$clog2(ENTRIES):0]   occupancy
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    logic [ENTRIES-1:0]           valid, lkp_match, upd_match, ctr_msb;
    logic [ENTRIES-1:0]           alloc_vec, upd_vec;
    logic [ENTRIES-1:0][PC_W-1:0] target;

    logic [IDX_W-1:0] rp_q, rp_d, free_idx, victim;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             free_found, full, alloc_en;
    logic [PC_W-1:0]  hit_target;
    logic             hit_msb;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        btb_entry #(.PC_W(PC_W)) u_ent (
            .clk          (clk),
            .rst          (rst),
            .flush_i      (flush),
            .alloc_i      (alloc_vec[g]),
            .upd_i        (upd_vec[g]),
            .upd_taken_i  (upd_taken),
            .upd_pc_i     (upd_pc),
            .upd_target_i (upd_target),
            .lkp_pc_i     (lkp_pc),
            .valid_o      (valid[g]),
            .lkp_match_o  (lkp_match[g]),
            .upd_match_o  (upd_match[g]),
            .ctr_msb_o    (ctr_msb[g]),
            .target_o     (target[g])
        );
    end

    // At most one entry matches a tag, so OR-reducing the selected fields is a mux.
    always_comb begin
        hit_target = '0;
        hit_msb    = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lkp_match[i]) begin
                hit_target = hit_target | target[i];
                hit_msb    = hit_msb | ctr_msb[i];
            end
        end
    end

    assign pred_hit     = lkp_valid && (|lkp_match);
    assign pred_taken   = pred_hit && hit_msb;
    assign pred_next_pc = pred_taken ? hit_target : lkp_pc + PC_W'(4);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign full      = !free_found;
    assign alloc_en  = upd_valid && upd_taken && !(|upd_match) && !flush;
    assign victim    = full ? rp_q : free_idx;
    assign alloc_vec = alloc_en ? (ENTRIES'(1) << victim) : '0;
    assign upd_vec   = upd_match & {ENTRIES{upd_valid && !flush}};

    always_comb begin
        rp_d  = rp_q;
        occ_d = occ_q;
        if (flush) begin
            rp_d  = '0;
            occ_d = '0;
        end else if (alloc_en) begin
            if (full) rp_d = (rp_q == IDX_W'(ENTRIES - 1)) ? '0 : rp_q + IDX_W'(1);
            else      occ_d = occ_q + OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp_q  <= '0;
            occ_q <= '0;
        end else begin
            rp_q  <= rp_d;
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
endmodule

// File: tb/tb_btb_2bit_predictor.sv
// Self-checking bench for btb_2bit_predictor: vector table plus directed
// replacement, flush and asynchronous-reset sequences, via a scoreboard queue.

module tb_btb_2bit_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lkp_valid, upd_valid, upd_taken, flush;
    logic [31:0] lkp_pc, upd_pc, upd_target;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_next_pc;
    logic [4:0]  occupancy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        lv;
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        fl;
        logic        ehit;
        logic        etaken;
        logic [31:0] enext;
        int          eocc;
    } vec_t;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] next;
        int          occ;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    btb_2bit_predictor #(.ENTRIES(16), .PC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .lkp_valid    (lkp_valid),
        .lkp_pc       (lkp_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .flush        (flush),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string n, input logic lv, input logic [31:0] lpc,
                                input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utgt, input logic fl, input logic eh,
                                input logic et, input logic [31:0] en, input int eo);
        vec_t v;
        v.name = n; v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut;
        v.utgt = utgt; v.fl = fl; v.ehit = eh; v.etaken = et; v.enext = en; v.eocc = eo;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, compare at the falling edge.
    task automatic step(input vec_t v);
        exp_t e;
        lkp_valid = v.lv; lkp_pc = v.lpc;
        upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut; upd_target = v.utgt;
        flush = v.fl;
        e.name = v.name; e.hit = v.ehit; e.taken = v.etaken; e.next = v.enext; e.occ = v.eocc;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check({e.name, ".hit"},   32'(pred_hit),   32'(e.hit));
        check({e.name, ".taken"}, 32'(pred_taken), 32'(e.taken));
        check({e.name, ".next"},  pred_next_pc,    e.next);
        check({e.name, ".occ"},   32'(occupancy),  32'(e.occ));
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl.push_back(mk("cold_miss",   1, 'h100, 0, 0, 0, 0, 0,        0, 0, 'h104, 0));
        tbl.push_back(mk("alloc_100",   1, 'h100, 1, 'h100, 1, 'h200, 0, 0, 0, 'h104, 0));
        tbl.push_back(mk("hit_10",      1, 'h100, 1, 'h100, 0, 0, 0,    1, 1, 'h200, 1));
        tbl.push_back(mk("ctr_01",      1, 'h100, 1, 'h100, 0, 0, 0,    1, 0, 'h104, 1));
        tbl.push_back(mk("ctr_00",      1, 'h100, 1, 'h100, 0, 0, 0,    1, 0, 'h104, 1));
        tbl.push_back(mk("sat_00",      1, 'h100, 1, 'h100, 1, 'h280, 0, 1, 0, 'h104, 1));
        tbl.push_back(mk("inc_01",      1, 'h100, 1, 'h100, 1, 'h2C0, 0, 1, 0, 'h104, 1));
        tbl.push_back(mk("ctr_10",      1, 'h100, 0, 0, 0, 0, 0,        1, 1, 'h2C0, 1));
        tbl.push_back(mk("inc_10",      1, 'h100, 1, 'h100, 1, 'h2C0, 0, 1, 1, 'h2C0, 1));
        tbl.push_back(mk("ctr_11",      1, 'h100, 1, 'h100, 1, 'h2C0, 0, 1, 1, 'h2C0, 1));
        tbl.push_back(mk("sat_11",      1, 'h100, 1, 'h100, 0, 0, 0,    1, 1, 'h2C0, 1));
        tbl.push_back(mk("dec_10",      1, 'h100, 1, 'h100, 0, 0, 0,    1, 1, 'h2C0, 1));
        tbl.push_back(mk("ctr_01b",     1, 'h100, 0, 0, 0, 0, 0,        1, 0, 'h104, 1));
        tbl.push_back(mk("nt_miss",     1, 'h700, 1, 'h700, 0, 'h900, 0, 0, 0, 'h704, 1));
        tbl.push_back(mk("no_alloc",    1, 'h700, 0, 0, 0, 0, 0,        0, 0, 'h704, 1));
        tbl.push_back(mk("hazard",      1, 'h300, 1, 'h300, 1, 'h900, 0, 0, 0, 'h304, 1));
        tbl.push_back(mk("hazard_nx",   1, 'h300, 0, 0, 0, 0, 0,        1, 1, 'h900, 2));
        tbl.push_back(mk("lkp_off",     0, 'h300, 0, 0, 0, 0, 0,        0, 0, 'h304, 2));
        tbl.push_back(mk("flush_upd",   1, 'h500, 1, 'h500, 1, 'h600, 1, 0, 0, 'h504, 2));
        tbl.push_back(mk("post_flush",  1, 'h500, 0, 0, 0, 0, 0,        0, 0, 'h504, 0));
        tbl.push_back(mk("flushed_100", 1, 'h100, 0, 0, 0, 0, 0,        0, 0, 'h104, 0));
        tbl.push_back(mk("wrap",        1, 'hFFFFFFFC, 0, 0, 0, 0, 0,   0, 0, 'h0, 0));
        tbl.push_back(mk("alloc_wrap",  1, 'hFFFFFFFC, 1, 'hFFFFFFFC, 1, 'h10, 0, 0, 0, 'h0, 0));
        tbl.push_back(mk("hit_wrap",    1, 'hFFFFFFFC, 0, 0, 0, 0, 0,   1, 1, 'h10, 1));

        lkp_valid = 1; lkp_pc = 'h100;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; flush = 0;
        @(posedge clk);
        #1;
        check("rst.hit",  32'(pred_hit),   0);
        check("rst.taken",32'(pred_taken), 0);
        check("rst.next", pred_next_pc,    'h104);
        check("rst.occ",  32'(occupancy),  0);
        rst = 0;

        foreach (tbl[i]) step(tbl[i]);

        // Fill all 16 entries, then replace through the round-robin pointer.
        step(mk("fill_flush", 1, 'h0, 0, 0, 0, 0, 1, 0, 0, 'h4, 1));
        for (int i = 0; i < 16; i++)
            step(mk($sformatf("fill%0d", i), 1, 32'(4*i), 1, 32'(4*i), 1, 32'('h1000 + 4*i), 0,
                    0, 0, 32'(4*i + 4), i));
        step(mk("full_hit_3c", 1, 'h3C, 0, 0, 0, 0, 0, 1, 1, 'h103C, 16));
        step(mk("repl_40",     1, 'h40, 1, 'h40, 1, 'h2000, 0, 0, 0, 'h44, 16));
        step(mk("evicted_0",   1, 'h0, 0, 0, 0, 0, 0, 0, 0, 'h4, 16));
        step(mk("hit_40",      1, 'h40, 0, 0, 0, 0, 0, 1, 1, 'h2000, 16));
        step(mk("kept_4",      1, 'h4, 0, 0, 0, 0, 0, 1, 1, 'h1004, 16));
        for (int k = 0; k < 16; k++)
            step(mk($sformatf("rr%0d", k), 0, 32'('h80 + 4*k), 1, 32'('h80 + 4*k), 1,
                    32'('h3000 + 4*k), 0, 0, 0, 32'('h84 + 4*k), 16));
        step(mk("rr_wrap",     0, 'hC0, 1, 'hC0, 1, 'h4000, 0, 0, 0, 'hC4, 16));
        step(mk("rr_evict_80", 1, 'h80, 0, 0, 0, 0, 0, 0, 0, 'h84, 16));
        step(mk("rr_kept_84",  1, 'h84, 0, 0, 0, 0, 0, 1, 1, 'h3004, 16));
        step(mk("rr_kept_bc",  1, 'hBC, 0, 0, 0, 0, 0, 1, 1, 'h303C, 16));
        step(mk("rr_gone_40",  1, 'h40, 0, 0, 0, 0, 0, 0, 0, 'h44, 16));
        step(mk("rr_hit_c0",   1, 'hC0, 0, 0, 0, 0, 0, 1, 1, 'h4000, 16));

        // Asynchronous reset between edges with five live entries.
        step(mk("ar_flush", 0, 'h0, 0, 0, 0, 0, 1, 0, 0, 'h4, 16));
        for (int j = 0; j < 5; j++)
            step(mk($sformatf("ar_alloc%0d", j), 1, 32'('hD00 + 4*j), 1, 32'('hD00 + 4*j), 1,
                    'hE00, 0, 0, 0, 32'('hD04 + 4*j), j));
        step(mk("ar_pre", 1, 'hD00, 0, 0, 0, 0, 0, 1, 1, 'hE00, 5));
        lkp_valid = 1; lkp_pc = 'hD00;
        upd_valid = 1; upd_pc = 'hA00; upd_taken = 1; upd_target = 'hA80; flush = 0;
        #2;
        rst = 1;
        #1;
        check("ar.occ",   32'(occupancy),  0);
        check("ar.hit",   32'(pred_hit),   0);
        check("ar.taken", 32'(pred_taken), 0);
        check("ar.next",  pred_next_pc,    'hD04);
        @(posedge clk);
        #1;
        upd_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        step(mk("rel_upd",   1, 'hB00, 1, 'hB00, 1, 'hC00, 0, 0, 0, 'hB04, 0));
        step(mk("rel_hit",   1, 'hB00, 0, 0, 0, 0, 0, 1, 1, 'hC00, 1));
        step(mk("rst_drop",  1, 'hA00, 0, 0, 0, 0, 0, 0, 0, 'hA04, 1));
        step(mk("rst_gone",  1, 'hD00, 0, 0, 0, 0, 0, 0, 0, 'hD04, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/btb_2bit_predictor.md
BTB_2BIT_PREDICTOR -- requirements
Module: btb_2bit_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of fully associative entries; power of two, 2..64.
REQ-002 SHALL have parameter PC_W, default 32: PC and target width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port lkp_valid  in  1  lookup request, IF stage.
REQ-007 SHALL have port lkp_pc  in  PC_W  PC being fetched.
REQ-008 SHALL have port pred_hit  out  1  lookup matched a valid entry.
REQ-009 SHALL have port pred_taken  out  1  predicted taken.
REQ-010 SHALL have port pred_next_pc  out  PC_W  predicted next fetch PC.
REQ-011 SHALL have port upd_valid  in  1  resolved branch/jump update, ID/EX stage.
REQ-012 SHALL have port upd_pc  in  PC_W  PC of the resolved branch.
REQ-013 SHALL have port upd_taken  in  1  actual direction.
REQ-014 SHALL have port upd_target  in  PC_W  actual target address.
REQ-015 SHALL have port flush  in  1  synchronous invalidate-all.
REQ-016 SHALL have port occupancy  out  $clog2(ENTRIES)+1  count of valid entries.

Function
REQ-017 SHALL store, per entry: valid bit, tag (full PC_W-bit PC), target (PC_W), 2-bit saturating counter.
REQ-018 SHALL compute lookup combinationally, with zero latency: pred_hit = lkp_valid AND a valid entry has tag == lkp_pc.
REQ-019 SHALL drive pred_taken = pred_hit AND counter[1] of the matching entry.
REQ-020 SHALL drive pred_next_pc = matching target when pred_taken; otherwise lkp_pc + 4, modulo 2^PC_W (wrap, no carry out).
REQ-021 SHALL keep at most one valid entry per tag, so no lookup matches more than one entry.
REQ-022 SHALL apply an update on the rising edge when upd_valid=1.
REQ-023 Update hit, upd_taken=1: SHALL increment the counter, saturating at 2'b11, and write target := upd_target.
REQ-024 Update hit, upd_taken=0: SHALL decrement the counter, saturating at 2'b00; target unchanged; entry stays valid.
REQ-025 Update miss, upd_taken=0: SHALL not allocate; no state change.
REQ-026 Update miss, upd_taken=1: SHALL allocate with valid=1, tag=upd_pc, target=upd_target, counter=2'b10 (weakly taken).
REQ-027 Allocation victim SHALL be the lowest-index invalid entry; when the buffer is full, it SHALL be the entry at the round-robin pointer rp.
REQ-028 rp SHALL advance by 1 (mod ENTRIES) only on an allocation into a full buffer; it wraps ENTRIES-1 -> 0.
REQ-029 occupancy SHALL increment on allocation into a non-full buffer, hold when full (replacement), and never exceed ENTRIES.
REQ-030 On a lookup and update in the same cycle to the same PC, the lookup SHALL see pre-edge contents; no bypass.
REQ-031 flush=1 SHALL clear all valid bits, occupancy and rp at the next edge; flush SHALL take priority over a same-cycle update, which is dropped.
REQ-032 Tag, target and counter fields of invalid entries SHALL not affect any output.

Reset
REQ-033 While rst=1, all valid bits, rp and occupancy SHALL be 0 immediately, without waiting for clk.
REQ-034 During reset, pred_hit=0, pred_taken=0 and pred_next_pc=lkp_pc+4.
REQ-035 Tag, target and counter arrays need no reset.
REQ-036 An update asserted in the cycle rst deasserts SHALL be applied at the first subsequent edge.
REQ-037 Reset asserted mid-update SHALL discard that update.

Verification
REQ-038 Cold miss: after reset, lkp_pc=0x100 -> pred_hit=0, pred_next_pc=0x104; update 0x100 taken to 0x200, then lkp 0x100 -> hit=1, taken=1, next=0x200, occupancy=1.
REQ-039 Counter saturation: from 2'b10, apply three not-taken updates to 0x100 -> after the 1st, taken=0 (counter 01); after the 3rd, counter 00; two taken updates -> counter 10, taken=1, next=upd_target.
REQ-040 Full replacement: allocate taken branches at 0x0,0x4,...,0x3C (16 entries), then 0x40 -> entry 0 replaced, lkp 0x0 misses, lkp 0x40 hits, occupancy=16, rp=1; 16 further allocations wrap rp back to 1.
REQ-041 Same-cycle hazard: lkp and update on 0x300 in the same cycle, first taken -> that cycle hit=0 and next=0x304; next cycle hit=1 and next=update target.
REQ-042 Flush priority: flush=1 with upd_valid=1 (taken, 0x500) -> next cycle occupancy=0, lkp 0x500 misses.
REQ-043 Async reset: assert rst between clock edges with occupancy=5 -> occupancy=0 and pred_hit=0 before the next edge; pred_next_pc wrap check: lkp_pc=0xFFFFFFFC -> 0x00000000.
